// File: rtl/gpio_pin_conditioner.sv
// Per-pin GPIO conditioning between the FPGA IO buffers and the register file:
// registered output/tristate drive, plus synchronise, glitch-filter and edge-capture on input.
module gpio_pin_conditioner #(
   parameter int WIDTH        = 8,
   parameter int SYNC_STAGES  = 2,   // legal range 2..4
   parameter int FILTER_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WIDTH-1:0]        pin_i,
   output logic [WIDTH-1:0]        pin_o,
   output logic [WIDTH-1:0]        pin_t,
   input  logic [WIDTH-1:0]        out_value,
   input  logic [WIDTH-1:0]        out_enable,
   input  logic [FILTER_WIDTH-1:0] filter_limit,
   input  logic [WIDTH-1:0]        irq_rise_en,
   input  logic [WIDTH-1:0]        irq_fall_en,
   input  logic [WIDTH-1:0]        irq_clear,
   output logic [WIDTH-1:0]        in_value,
   output logic [WIDTH-1:0]        rise_pending,
   output logic [WIDTH-1:0]        fall_pending,
   output logic                    irq
);

   logic [WIDTH-1:0]        sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]        sync_s;
   logic [FILTER_WIDTH-1:0] cnt_q  [WIDTH];
   logic [FILTER_WIDTH-1:0] cnt_d  [WIDTH];
   logic [WIDTH-1:0]        in_q, in_d;
   logic [WIDTH-1:0]        rise_q, rise_d;
   logic [WIDTH-1:0]        fall_q, fall_d;
   logic [WIDTH-1:0]        pin_o_q, pin_t_q;

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
      in_d   = in_q;
      rise_d = rise_q & ~irq_clear;
      fall_d = fall_q & ~irq_clear;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_s[i] != in_q[i]) begin
            // >= so that lowering filter_limit below a running count accepts at once
            if (cnt_q[i] >= filter_limit) begin
               in_d[i] = sync_s[i];
               if (sync_s[i] && irq_rise_en[i]) rise_d[i] = 1'b1;
               if (!sync_s[i] && irq_fall_en[i]) fall_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + FILTER_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
         in_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         pin_o_q <= '0;
         pin_t_q <= '1;   // every pad released to high-Z while in reset
      end else begin
         // NOTE: non-blocking assignments here so every flop samples pre-edge values; blocking would collapse the sync chain.
         sync_q[0] <= pin_i;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
         in_q    <= in_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         pin_o_q <= out_value;
         pin_t_q <= ~out_enable;
      end
   end

   assign pin_o        = pin_o_q;
   assign pin_t        = pin_t_q;
   assign in_value     = in_q;
   assign rise_pending = rise_q;
   assign fall_pending = fall_q;
   assign irq          = |{rise_q, fall_q};

endmodule

// File: tb/tb_gpio_pin_conditioner.sv
// Directed-vector bench for gpio_pin_conditioner with hand-computed expectations.
module tb_gpio_pin_conditioner;

   logic       clk;
   logic       reset;
   logic [7:0] pin_i, pin_o, pin_t;
   logic [7:0] out_value, out_enable;
   logic [3:0] filter_limit;
   logic [7:0] irq_rise_en, irq_fall_en, irq_clear;
   logic [7:0] in_value, rise_pending, fall_pending;
   logic       irq;

   int checks = 0;
   int errors = 0;

   gpio_pin_conditioner #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_WIDTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .pin_i        (pin_i),
      .pin_o        (pin_o),
      .pin_t        (pin_t),
      .out_value    (out_value),
      .out_enable   (out_enable),
      .filter_limit (filter_limit),
      .irq_rise_en  (irq_rise_en),
      .irq_fall_en  (irq_fall_en),
      .irq_clear    (irq_clear),
      .in_value     (in_value),
      .rise_pending (rise_pending),
      .fall_pending (fall_pending),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance n rising edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      for (int j = 0; j < n; j++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset        = 1'b1;
      pin_i        = 8'hFF;
      out_value    = 8'hFF;
      out_enable   = 8'hFF;
      filter_limit = 4'd0;
      irq_rise_en  = 8'h00;
      irq_fall_en  = 8'h00;
      irq_clear    = 8'h00;

      // reset state, before any clock edge
      #1;
      check("rst_pin_t", pin_t, 8'hFF);
      check("rst_pin_o", pin_o, 8'h00);
      check("rst_irq", irq, 1'b0);
      check("rst_in_value", in_value, 8'h00);
      check("rst_rise", rise_pending, 8'h00);

      #2;
      reset = 1'b0;
      pin_i = 8'h00;
      tick(1);
      check("rel_pin_t", pin_t, 8'h00);
      check("rel_pin_o", pin_o, 8'hFF);

      // output path, one-cycle latency
      out_value  = 8'hA5;
      out_enable = 8'h0F;
      #2;
      check("out_pre_pin_o", pin_o, 8'hFF);
      tick(1);
      check("out_pin_o", pin_o, 8'hA5);
      check("out_pin_t", pin_t, 8'hF0);

      // filter latency, limit 3: accepted after edge 6
      tick(4);
      filter_limit = 4'd3;
      pin_i = 8'h01;
      for (int e = 1; e <= 5; e++) begin
         tick(1);
         check($sformatf("lat3_e%0d", e), in_value[0], 1'b0);
      end
      tick(1);
      check("lat3_e6", in_value[0], 1'b1);
      pin_i = 8'h00;
      tick(8);
      check("lat3_back", in_value, 8'h00);

      // filter latency, limit 0: accepted after edge 3
      filter_limit = 4'd0;
      pin_i = 8'h01;
      tick(2);
      check("lat0_e2", in_value[0], 1'b0);
      tick(1);
      check("lat0_e3", in_value[0], 1'b1);
      pin_i = 8'h00;
      tick(4);
      check("lat0_back", in_value, 8'h00);

      // glitch: 3-cycle pulse rejected, 4-cycle accepted
      filter_limit = 4'd3;
      irq_rise_en  = 8'h04;
      pin_i = 8'h04;
      tick(3);
      pin_i = 8'h00;
      tick(8);
      check("glitch3_in", in_value[2], 1'b0);
      check("glitch3_rise", rise_pending, 8'h00);
      check("glitch3_irq", irq, 1'b0);
      pin_i = 8'h04;
      tick(4);
      pin_i = 8'h00;
      tick(1);
      check("pulse4_e5", in_value[2], 1'b0);
      tick(1);
      check("pulse4_e6", in_value[2], 1'b1);
      check("pulse4_rise", rise_pending, 8'h04);
      tick(6);
      check("pulse4_back", in_value[2], 1'b0);
      irq_clear = 8'h04;
      tick(1);
      irq_clear = 8'h00;
      check("pulse4_clr", rise_pending, 8'h00);
      irq_rise_en = 8'h00;

      // interrupts on pin 0: rise enabled, fall disabled
      filter_limit = 4'd0;
      irq_rise_en  = 8'h01;
      irq_fall_en  = 8'h00;
      pin_i = 8'h01;
      tick(3);
      pin_i = 8'h00;
      tick(3);
      check("irq_in_low", in_value[0], 1'b0);
      check("irq_rise", rise_pending, 8'h01);
      check("irq_fall", fall_pending, 8'h00);
      check("irq_out", irq, 1'b1);
      // clear on the same edge as a new filtered rise: set wins
      pin_i = 8'h01;
      tick(2);
      irq_clear = 8'h01;
      tick(1);
      irq_clear = 8'h00;
      check("setwin_in", in_value[0], 1'b1);
      check("setwin_rise", rise_pending, 8'h01);
      // disabling the enable keeps the pending bit
      irq_rise_en = 8'h00;
      tick(1);
      check("dis_keep", rise_pending, 8'h01);
      irq_clear = 8'h01;
      tick(1);
      irq_clear = 8'h00;
      check("lone_clr_rise", rise_pending, 8'h00);
      check("lone_clr_irq", irq, 1'b0);
      // falling edge with fall enable
      irq_fall_en = 8'h01;
      pin_i = 8'h00;
      tick(3);
      check("fall_set", fall_pending, 8'h01);
      check("fall_irq", irq, 1'b1);
      check("fall_norise", rise_pending, 8'h00);

      // async reset mid-count and mid-drive, limit 7
      filter_limit = 4'd7;
      pin_i = 8'h02;
      tick(4);
      check("mid_pre_in", in_value, 8'h00);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_in", in_value, 8'h00);
      check("mid_rst_fall", fall_pending, 8'h00);
      check("mid_rst_irq", irq, 1'b0);
      check("mid_rst_pin_t", pin_t, 8'hFF);
      check("mid_rst_pin_o", pin_o, 8'h00);
      #1;
      reset = 1'b0;
      tick(1);
      check("mid_rel_pin_t", pin_t, 8'hF0);
      tick(8);
      check("mid_rel_e9", in_value, 8'h00);
      tick(1);
      check("mid_rel_e10", in_value, 8'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no end expected end");
      $fatal(1, "timeout");
   end

endmodule
